fetch_stage: RTL and testbench

- Instruction-fetch stage; sits directly upstream of the F/D pipeline register and drives its InstrF input.
- Owns the program counter and issues single-outstanding requests to instruction memory, which has variable latency.
- Presents each fetched word to decode for one consuming cycle.
- Handles decode stall and execute-stage branch redirect.
- Inserts the NOP encoding 32'hC000_0000 whenever no valid instruction is available. This is the same value the F/D register resets to.

---
 rtl/fetch_stage_pkg.sv | 16 +
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, the bubble
// instruction (also the F/D register reset value) and the reset PC.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

    localparam logic [31:0] FD_NOP_INSTR     = 32'hC000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_PC_STEP  = 4;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to
// variable-latency instruction memory, and feeds decode one word at a time.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                    PC_STEP    = DEFAULT_PC_STEP,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = FD_NOP_INSTR
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  StallF,
    input  logic                  RedirectE,
    input  logic [ADDR_WIDTH-1:0] TargetE,
    fetch_stage_if.master         imem,
    output logic [DATA_WIDTH-1:0] InstrF,
    output logic                  ValidF,
    output logic [ADDR_WIDTH-1:0] PCF,
    output logic [ADDR_WIDTH-1:0] PCPlus4F,
    output logic                  ProtoErr
);

    fetch_state_t          state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n;
    logic [DATA_WIDTH-1:0] buffer, buffer_n;
    logic                  protoerr, protoerr_n;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            buffer   <= NOP_INSTR;
            protoerr <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            buffer   <= buffer_n;
            protoerr <= protoerr_n;
        end
    end

    // A redirect always wins; a response that arrives after a redirect in WAIT
    // belongs to the old path and is swallowed in DROP.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        buffer_n   = buffer;
        protoerr_n = protoerr;
        case (state)
            FETCH: begin
                if (imem.imem_rvalid) protoerr_n = 1'b1;
                if (RedirectE) pc_n = TargetE;
                else           state_n = WAIT;
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    if (RedirectE) begin
                        pc_n    = TargetE;
                        state_n = FETCH;
                    end else begin
                        buffer_n = imem.imem_rdata;
                        state_n  = HOLD;
                    end
                end else if (RedirectE) begin
                    pc_n    = TargetE;
                    state_n = DROP;
                end
            end
            HOLD: begin
                if (imem.imem_rvalid) protoerr_n = 1'b1;
                if (RedirectE) begin
                    pc_n     = TargetE;
                    buffer_n = NOP_INSTR;
                    state_n  = FETCH;
                end else if (!StallF) begin
                    pc_n    = pc + ADDR_WIDTH'(PC_STEP);
                    state_n = FETCH;
                end
            end
            DROP: begin
                if (RedirectE)        pc_n = TargetE;
                if (imem.imem_rvalid) state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

    assign imem.imem_req  = (state == FETCH) && !RedirectE && !RST;
    assign imem.imem_addr = pc;
    assign ValidF         = (state == HOLD);
    assign InstrF         = (state == HOLD) ? buffer : NOP_INSTR;
    assign PCF            = pc;
    assign PCPlus4F       = pc + ADDR_WIDTH'(PC_STEP);
    assign ProtoErr       = protoerr;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run against a flag-level behavioural model with a variable-latency memory.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hC000_0000;

    logic        CLK;
    logic        RST;
    logic        StallF;
    logic        RedirectE;
    logic [31:0] TargetE;
    logic [31:0] InstrF;
    logic        ValidF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        ProtoErr;

    int assertions = 0;
    int failures   = 0;

    fetch_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) imem_bus ();

    fetch_stage dut (
        .CLK      (CLK),
        .RST      (RST),
        .StallF   (StallF),
        .RedirectE(RedirectE),
        .TargetE  (TargetE),
        .imem     (imem_bus),
        .InstrF   (InstrF),
        .ValidF   (ValidF),
        .PCF      (PCF),
        .PCPlus4F (PCPlus4F),
        .ProtoErr (ProtoErr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ a[15:0] ^ 16'h1234};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] tgt,
                                 input logic rv, input logic [31:0] rd);
        StallF               = stall;
        RedirectE            = redir;
        TargetE              = tgt;
        imem_bus.imem_rvalid = rv;
        imem_bus.imem_rdata  = rd;
    endtask

    task automatic applyReset();
        RST = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        assertions++;
        if (ValidF !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0b expected 0", ValidF); end
        assertions++;
        if (InstrF !== NOP) begin failures++; $display("[TB] FAIL reset_instr: got %h expected %h", InstrF, NOP); end
        assertions++;
        if (PCF !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc: got %h expected 0", PCF); end
        assertions++;
        if (PCPlus4F !== 32'h4) begin failures++; $display("[TB] FAIL reset_pcplus4: got %h expected 4", PCPlus4F); end
        assertions++;
        if (imem_bus.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req: got %0b expected 0", imem_bus.imem_req); end
        assertions++;
        if (ProtoErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_protoerr: got %0b expected 0", ProtoErr); end
        step();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_basic_fetch();
        applyReset();
        assertions++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin
            failures++; $display("[TB] FAIL basic_req0: got req=%0b addr=%h expected req=1 addr=0", imem_bus.imem_req, imem_bus.imem_addr);
        end
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_0001);
        #1;
        assertions++;
        if (ValidF !== 1'b0) begin failures++; $display("[TB] FAIL basic_wait_valid: got %0b expected 0", ValidF); end
        step();
        imem_bus.imem_rvalid = 1'b0;
        #1;
        assertions++;
        if (ValidF !== 1'b1 || InstrF !== 32'h1111_0001 || PCF !== 32'h0) begin
            failures++; $display("[TB] FAIL basic_hold: got valid=%0b instr=%h pc=%h expected 1/11110001/0", ValidF, InstrF, PCF);
        end
        step();
        assertions++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h4) begin
            failures++; $display("[TB] FAIL basic_next_addr: got req=%0b addr=%h expected req=1 addr=4", imem_bus.imem_req, imem_bus.imem_addr);
        end
    endtask

    task automatic test_stall();
        applyReset();
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h2222_0002);
        step();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            assertions++;
            if (ValidF !== 1'b1 || InstrF !== 32'h2222_0002 || PCF !== 32'h0 || imem_bus.imem_req !== 1'b0) begin
                failures++; $display("[TB] FAIL stall_hold_%0d: got valid=%0b instr=%h pc=%h req=%0b expected 1/22220002/0/0",
                                     i, ValidF, InstrF, PCF, imem_bus.imem_req);
            end
            step();
        end
        StallF = 1'b0;
        step();
        assertions++;
        if (PCF !== 32'h4 || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h4) begin
            failures++; $display("[TB] FAIL stall_release: got pc=%h req=%0b addr=%h expected 4/1/4", PCF, imem_bus.imem_req, imem_bus.imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        applyReset();
        step();
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        step();
        RedirectE = 1'b0;
        #1;
        assertions++;
        if (PCF !== 32'h100 || imem_bus.imem_req !== 1'b0 || ValidF !== 1'b0) begin
            failures++; $display("[TB] FAIL redir_drop: got pc=%h req=%0b valid=%0b expected 100/0/0", PCF, imem_bus.imem_req, ValidF);
        end
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        #1;
        assertions++;
        if (InstrF !== NOP || imem_bus.imem_req !== 1'b0) begin
            failures++; $display("[TB] FAIL redir_orphan: got instr=%h req=%0b expected %h/0", InstrF, imem_bus.imem_req, NOP);
        end
        step();
        imem_bus.imem_rvalid = 1'b0;
        #1;
        assertions++;
        if (InstrF !== NOP || ValidF !== 1'b0 || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h100 || ProtoErr !== 1'b0) begin
            failures++; $display("[TB] FAIL redir_refetch: got instr=%h valid=%0b req=%0b addr=%h perr=%0b expected %h/0/1/100/0",
                                 InstrF, ValidF, imem_bus.imem_req, imem_bus.imem_addr, ProtoErr, NOP);
        end
    endtask

    task automatic test_redirect_stall_hold();
        applyReset();
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h3333_0003);
        step();
        applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
        #1;
        assertions++;
        if (ValidF !== 1'b1 || InstrF !== 32'h3333_0003) begin
            failures++; $display("[TB] FAIL rsh_hold: got valid=%0b instr=%h expected 1/33330003", ValidF, InstrF);
        end
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        assertions++;
        if (ValidF !== 1'b0 || InstrF !== NOP || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h200) begin
            failures++; $display("[TB] FAIL rsh_redirect: got valid=%0b instr=%h req=%0b addr=%h expected 0/%h/1/200",
                                 ValidF, InstrF, imem_bus.imem_req, imem_bus.imem_addr, NOP);
        end
    endtask

    task automatic test_protoerr();
        applyReset();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h4444_0004);
        #1;
        assertions++;
        if (InstrF !== NOP) begin failures++; $display("[TB] FAIL perr_instr: got %h expected %h", InstrF, NOP); end
        step();
        imem_bus.imem_rvalid = 1'b0;
        #1;
        assertions++;
        if (ProtoErr !== 1'b1 || ValidF !== 1'b0) begin
            failures++; $display("[TB] FAIL perr_set: got perr=%0b valid=%0b expected 1/0", ProtoErr, ValidF);
        end
        step();
        step();
        assertions++;
        if (ProtoErr !== 1'b1) begin failures++; $display("[TB] FAIL perr_sticky: got %0b expected 1", ProtoErr); end
        RST = 1'b1;
        #1;
        assertions++;
        if (ProtoErr !== 1'b0) begin failures++; $display("[TB] FAIL perr_clear: got %0b expected 0", ProtoErr); end
        step();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset_midwait();
        applyReset();
        applyStimulus(1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
        #1;
        assertions++;
        if (imem_bus.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL rmw_redir_req: got %0b expected 0", imem_bus.imem_req); end
        step();
        RedirectE = 1'b0;
        #1;
        assertions++;
        if (PCF !== 32'h300 || imem_bus.imem_req !== 1'b1) begin
            failures++; $display("[TB] FAIL rmw_fetch: got pc=%h req=%0b expected 300/1", PCF, imem_bus.imem_req);
        end
        step();
        #2;
        RST = 1'b1;
        #1;
        assertions++;
        if (ValidF !== 1'b0 || InstrF !== NOP || PCF !== 32'h0 || imem_bus.imem_req !== 1'b0) begin
            failures++; $display("[TB] FAIL rmw_async: got valid=%0b instr=%h pc=%h req=%0b expected 0/%h/0/0",
                                 ValidF, InstrF, PCF, imem_bus.imem_req, NOP);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_0005);
        step();
        imem_bus.imem_rvalid = 1'b0;
        RST = 1'b0;
        #1;
        assertions++;
        if (ProtoErr !== 1'b0 || imem_bus.imem_req !== 1'b1 || ValidF !== 1'b0) begin
            failures++; $display("[TB] FAIL rmw_release: got perr=%0b req=%0b valid=%0b expected 0/1/0", ProtoErr, imem_bus.imem_req, ValidF);
        end
    endtask

    task automatic test_random();
        logic        m_out, m_disc, m_have, exp_req;
        logic [31:0] m_pc, m_instr, tgt, rd;
        logic        stall, redir, rv;
        bit          mem_pend;
        int          mem_cnt;
        logic [31:0] mem_addr;
        applyReset();
        m_out = 0; m_disc = 0; m_have = 0; m_pc = 32'h0; m_instr = NOP;
        mem_pend = 0; mem_cnt = 0; mem_addr = 32'h0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            stall = ($urandom_range(0, 9) < 3);
            redir = ($urandom_range(0, 9) == 0);
            tgt   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            rv = 1'b0;
            rd = $urandom();
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    rv = 1'b1;
                    rd = memfn(mem_addr);
                    mem_pend = 0;
                end
            end
            applyStimulus(stall, redir, tgt, rv, rd);
            #1;
            exp_req = !m_out && !m_have && !redir;
            assertions++;
            if (imem_bus.imem_req !== exp_req || (exp_req && imem_bus.imem_addr !== m_pc)) begin
                failures++; $display("[TB] FAIL rand_req c%0d: got req=%0b addr=%h expected req=%0b addr=%h",
                                     cyc, imem_bus.imem_req, imem_bus.imem_addr, exp_req, m_pc);
            end
            assertions++;
            if (ValidF !== m_have || InstrF !== (m_have ? m_instr : NOP)) begin
                failures++; $display("[TB] FAIL rand_instr c%0d: got valid=%0b instr=%h expected valid=%0b instr=%h",
                                     cyc, ValidF, InstrF, m_have, m_have ? m_instr : NOP);
            end
            assertions++;
            if (PCF !== m_pc || PCPlus4F !== m_pc + 32'd4 || ProtoErr !== 1'b0) begin
                failures++; $display("[TB] FAIL rand_pc c%0d: got pc=%h pc4=%h perr=%0b expected %h/%h/0",
                                     cyc, PCF, PCPlus4F, ProtoErr, m_pc, m_pc + 32'd4);
            end
            if (imem_bus.imem_req === 1'b1 && !mem_pend) begin
                mem_pend = 1;
                mem_addr = imem_bus.imem_addr;
                mem_cnt  = $urandom_range(1, 3);
            end
            // Model: a fetch is outstanding, possibly orphaned by a redirect,
            // or a captured word waits for decode to take it.
            if (redir) begin
                m_pc   = tgt;
                m_have = 0;
                if (m_out && rv) begin m_out = 0; m_disc = 0; end
                else if (m_out)  m_disc = 1;
            end else if (!m_out && !m_have) begin
                m_out  = 1;
                m_disc = 0;
            end else if (m_out && rv) begin
                m_out = 0;
                if (!m_disc) begin m_have = 1; m_instr = rd; end
                m_disc = 0;
            end else if (m_have && !stall) begin
                m_have = 0;
                m_pc   = m_pc + 32'd4;
            end
            step();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        RST = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_stall_hold();
        test_protoerr();
        test_reset_midwait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
